// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared sizing and functional-unit latency constants for the
//            decode-stage hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int NREG = 32;
    localparam int LATW = 3;
    localparam int REGW = 5;

    localparam logic [LATW-1:0] LAT_ALU  = LATW'(0);
    localparam logic [LATW-1:0] LAT_LOAD = LATW'(1);
    localparam logic [LATW-1:0] LAT_MUL  = LATW'(3);

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : sb_entry
// Purpose  : One scoreboard slot: busy flag plus result-ready countdown.
// Revision : 1.0 - initial release
// ============================================================================
module sb_entry
    import riscv_pkg::*;
#(
    parameter int CNTW = riscv_pkg::LATW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            kill,
    input  logic            alloc,
    input  logic            wb,
    input  logic [CNTW-1:0] lat,
    output logic            busy,
    output logic [CNTW-1:0] cnt,
    output logic            busy_nxt
);

    logic            r_busy;
    logic [CNTW-1:0] r_cnt;
    logic            w_busy_nxt;
    logic [CNTW-1:0] w_cnt_nxt;

    // Squash beats a new producer, a new producer beats its older write-back.
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt;
        if (kill) begin
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end else if (alloc) begin
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = lat;
        end else if (wb) begin
            w_busy_nxt = 1'b0;
            w_cnt_nxt  = '0;
        end else if (r_cnt != '0) begin
            w_cnt_nxt  = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy     = r_busy;
    assign cnt      = r_cnt;
    assign busy_nxt = w_busy_nxt;

endmodule : sb_entry
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Decode-stage RAW hazard scoreboard with latency-aware forwarding,
//            WAW reallocation and single-instruction flush.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG = riscv_pkg::NREG,
    parameter int LATW = riscv_pkg::LATW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_regwrite,
    input  logic [4:0]      issue_rd,
    input  logic [LATW-1:0] issue_latency,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic [4:0]      RS1,
    input  logic [4:0]      RS2,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            stall,
    output logic [5:0]      busy_count
);

    logic [NREG-1:0] w_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [LATW-1:0] w_cnt [NREG];
    logic            w_pend1;
    logic            w_pend2;
    logic            w_accept;
    logic            w_alloc;
    logic            w_kill_any;
    logic [5:0]      w_pop;

    logic [4:0]      r_last_rd;
    logic            r_last_alloc;
    logic [5:0]      r_busy_count;

    // A busy source whose countdown has expired is forwardable, so no stall.
    assign w_pend1 = use_rs1 && (RS1 != 5'd0) && w_busy[RS1] && (w_cnt[RS1] != '0);
    assign w_pend2 = use_rs2 && (RS2 != 5'd0) && w_busy[RS2] && (w_cnt[RS2] != '0);
    assign stall   = !reset && issue_valid && (w_pend1 || w_pend2);

    assign w_accept   = issue_valid && !stall;
    assign w_alloc    = w_accept && !flush && issue_regwrite && (issue_rd != 5'd0);
    assign w_kill_any = flush && r_last_alloc;

    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
        sb_entry #(
            .CNTW (LATW)
        ) u_entry (
            .clk      (clk),
            .reset    (reset),
            .kill     (w_kill_any && (r_last_rd == 5'(gi))),
            .alloc    (w_alloc && (issue_rd == 5'(gi))),
            .wb       (wb_valid && (wb_rd != 5'd0) && (wb_rd == 5'(gi))),
            .lat      (issue_latency),
            .busy     (w_busy[gi]),
            .cnt      (w_cnt[gi]),
            .busy_nxt (w_busy_nxt[gi])
        );
    end : g_entry

    // Count the post-edge busy vector so the register matches entry state.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NREG; i++) begin
            w_pop = w_pop + 6'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_rd    <= 5'd0;
            r_last_alloc <= 1'b0;
            r_busy_count <= 6'd0;
        end else begin
            r_busy_count <= w_pop;
            if (w_alloc) begin
                r_last_rd    <= issue_rd;
                r_last_alloc <= 1'b1;
            end else begin
                r_last_rd    <= 5'd0;
                r_last_alloc <= 1'b0;
            end
        end
    end

    assign busy_count = r_busy_count;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Directed and randomized checks of hazard_scoreboard against a
//            ready-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
    import riscv_pkg::*;

    localparam int TB_NREG = 32;
    localparam int TB_LATW = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               issue_valid;
    logic               issue_regwrite;
    logic [4:0]         issue_rd;
    logic [TB_LATW-1:0] issue_latency;
    logic               use_rs1;
    logic               use_rs2;
    logic [4:0]         RS1;
    logic [4:0]         RS2;
    logic               wb_valid;
    logic [4:0]         wb_rd;
    logic               flush;
    logic               stall;
    logic [5:0]         busy_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG (TB_NREG),
        .LATW (TB_LATW)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_rd       (issue_rd),
        .issue_latency  (issue_latency),
        .use_rs1        (use_rs1),
        .use_rs2        (use_rs2),
        .RS1            (RS1),
        .RS2            (RS2),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flush          (flush),
        .stall          (stall),
        .busy_count     (busy_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: each register remembers the cycle at which its result
    // becomes forwardable rather than a running countdown.
    bit       m_busy  [TB_NREG];
    int       m_ready [TB_NREG];
    int       cyc = 0;
    bit [4:0] m_last_rd = '0;
    bit       m_last_alloc = 1'b0;

    function automatic bit m_pending(input logic [4:0] r);
        return (r != 5'd0) && m_busy[r] && (m_ready[r] > cyc);
    endfunction

    function automatic bit m_stall();
        return !reset && issue_valid &&
               ((use_rs1 && m_pending(RS1)) || (use_rs2 && m_pending(RS2)));
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < TB_NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_edge();
        bit       st;
        bit       alloc;
        bit       fl;
        bit [4:0] flr;
        st    = m_stall();
        alloc = issue_valid && !st && !flush && issue_regwrite && (issue_rd != 5'd0);
        fl    = flush && m_last_alloc;
        flr   = m_last_rd;
        if (reset) begin
            for (int i = 0; i < TB_NREG; i++) begin
                m_busy[i]  = 1'b0;
                m_ready[i] = 0;
            end
            m_last_rd    = '0;
            m_last_alloc = 1'b0;
        end else begin
            if (wb_valid && wb_rd != 5'd0) begin
                m_busy[wb_rd]  = 1'b0;
                m_ready[wb_rd] = 0;
            end
            if (alloc) begin
                m_busy[issue_rd]  = 1'b1;
                m_ready[issue_rd] = cyc + 1 + int'(issue_latency);
            end
            if (fl) begin
                m_busy[flr]  = 1'b0;
                m_ready[flr] = 0;
            end
            m_last_alloc = alloc;
            m_last_rd    = alloc ? issue_rd : 5'd0;
        end
        cyc++;
    endtask

    // Checks the current cycle at the falling edge, then advances one clock.
    task automatic step();
        @(negedge clk);
        check_val("stall", 32'(stall), 32'(m_stall()));
        check_val("busy_count", 32'(busy_count), 32'(m_count()));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_regwrite = 1'b0; issue_rd = '0; issue_latency = '0;
        use_rs1 = 1'b0; use_rs2 = 1'b0; RS1 = '0; RS2 = '0;
        wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic issue_w(input logic [4:0] rd, input logic [TB_LATW-1:0] lat);
        idle();
        issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = rd; issue_latency = lat;
        step();
    endtask

    task automatic probe_rs1(input logic [4:0] r);
        idle();
        issue_valid = 1'b1; use_rs1 = 1'b1; RS1 = r;
    endtask

    initial begin
        for (int i = 0; i < TB_NREG; i++) begin
            m_busy[i]  = 1'b0;
            m_ready[i] = 0;
        end
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_bc", 32'(busy_count), 32'd0);
        issue_valid = 1'b1; use_rs1 = 1'b1; RS1 = 5'd3;
        #1;
        check_val("rst_stall", 32'(stall), 32'd0);
        step();
        reset = 1'b0;

        // Load-use: one-cycle stall, then forwarding.
        issue_w(5'd5, LAT_LOAD);
        probe_rs1(5'd5);
        #1; check_val("lu_stall1", 32'(stall), 32'd1);
        step();
        #1; check_val("lu_stall0", 32'(stall), 32'd0);
        step();

        // x0 is never a hazard.
        do_reset();
        issue_w(5'd0, LAT_MUL);
        idle();
        issue_valid = 1'b1; use_rs2 = 1'b1; RS2 = 5'd0;
        #1; check_val("x0_stall", 32'(stall), 32'd0);
        check_val("x0_bc", 32'(busy_count), 32'd0);
        step();

        // WAW: reallocation wins over the older write-back.
        do_reset();
        issue_w(5'd7, LAT_MUL);
        idle();
        wb_valid = 1'b1; wb_rd = 5'd7;
        issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 5'd7; issue_latency = 3'd2;
        step();
        probe_rs1(5'd7);
        #1; check_val("waw_bc", 32'(busy_count), 32'd1);
        check_val("waw_stall_a", 32'(stall), 32'd1);
        step();
        #1; check_val("waw_stall_b", 32'(stall), 32'd1);
        step();
        #1; check_val("waw_release", 32'(stall), 32'd0);
        step();

        // Flush squashes the previous allocation.
        do_reset();
        issue_w(5'd9, LAT_MUL);
        idle();
        flush = 1'b1;
        step();
        probe_rs1(5'd9);
        #1; check_val("fl_bc", 32'(busy_count), 32'd0);
        check_val("fl_stall", 32'(stall), 32'd0);
        step();

        // Reset clears a populated scoreboard.
        do_reset();
        issue_w(5'd3, LAT_MUL);
        issue_w(5'd4, LAT_MUL);
        issue_w(5'd5, LAT_MUL);
        idle();
        #1; check_val("pre_rst_bc", 32'(busy_count), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        probe_rs1(5'd3);
        #1; check_val("post_rst_bc", 32'(busy_count), 32'd0);
        check_val("post_rst_stall", 32'(stall), 32'd0);
        step();

        for (int n = 0; n < 600; n++) begin
            idle();
            reset          = ($urandom_range(0, 49) == 0);
            issue_valid    = ($urandom_range(0, 3) != 0);
            issue_regwrite = 1'($urandom_range(0, 1));
            issue_rd       = 5'($urandom_range(0, 7));
            issue_latency  = 3'($urandom_range(0, 7));
            use_rs1        = 1'($urandom_range(0, 1));
            use_rs2        = 1'($urandom_range(0, 1));
            RS1            = 5'($urandom_range(0, 7));
            RS2            = 5'($urandom_range(0, 7));
            wb_valid       = ($urandom_range(0, 2) == 0);
            wb_rd          = 5'($urandom_range(0, 7));
            flush          = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
